// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder computing {Cout, Sum} = A + B + Cin.
// One 1-bit full adder is reused over WIDTH cycles, LSB first. The control
// FSM steps IDLE -> RUN (WIDTH cycles) -> DONE (one cycle) -> IDLE.
// Optional macro SERIAL_ADDER_LED_INV_EN inverts the LED indicator bus for
// active-low board LEDs. Nothing else depends on it.
module serial_adder_ctrl #(
  parameter int WIDTH = 4  // operand width, legal range 2..16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH+1:0] LED
);

  // The counter holds 0..WIDTH, so it never wraps within an operation.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  // The partial result only needs WIDTH-1 bits: the WIDTH-th sum bit goes
  // straight into Sum on the final RUN edge together with the rest.
  logic [WIDTH-2:0] res_sh;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Single full adder on the operand LSBs and the running carry.
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  // New sum bit enters at the MSB; earlier bits move one place toward the LSB.
  assign res_next = {fa_sum, res_sh};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and status outputs, decoded from the current state.
  // NOTE: every output of this block is given a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    unique case (state)
      IDLE: if (Start) state_next = RUN;
      RUN: begin
        Busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on Start, shift one bit per RUN cycle, and
  // publish the full result only on the last RUN edge.
  // NOTE: every register here is a handful of flops, so all of them take the
  // async reset; a reset mid-operation clears the partial state completely.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      res_sh <= '0;
      cnt    <= '0;
      Sum    <= '0;
      Cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_carry;
          res_sh <= res_next[WIDTH-1:1];
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            Sum  <= res_next;
            Cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_LED_INV_EN
  assign LED = ~{Done, Cout, Sum};
`else
  assign LED = {Done, Cout, Sum};
`endif

endmodule
